// File: rtl/eth_mac_cfg_seq.sv
// Bring-up sequencer for the C5_ETH MAC control port: reset, address/length setup,
// TX/RX enable and read-back verify, then pass the port through to a host master.
module eth_mac_cfg_seq #(
    parameter logic [47:0] MAC_ADDR = 48'h0002_C5E7_0001,
    parameter logic [31:0] FRM_LEN  = 32'd1518,
    parameter logic [31:0] CMD_RUN  = 32'h0000_0003,
    parameter int unsigned TIMEOUT  = 1023,
    parameter int unsigned POLL_MAX = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [1:0]  err_code,
    output logic [7:0]  reg_addr,
    output logic        reg_rd,
    output logic        reg_wr,
    output logic [31:0] reg_data_in,
    input  logic [31:0] reg_data_out,
    input  logic        reg_busy,
    input  logic [7:0]  host_addr,
    input  logic        host_rd,
    input  logic        host_wr,
    input  logic [31:0] host_wdata,
    output logic [31:0] host_rdata,
    output logic        host_busy
);

    localparam int unsigned BusyW = $clog2(TIMEOUT + 1);
    localparam int unsigned PollW = $clog2(POLL_MAX + 1);
    localparam logic [BusyW-1:0] BusyLast = BusyW'(TIMEOUT - 1);
    localparam logic [PollW-1:0] PollLast = PollW'(POLL_MAX - 1);

    localparam logic [7:0]  AddrCmd  = 8'h02;
    localparam logic [7:0]  AddrMac0 = 8'h03;
    localparam logic [7:0]  AddrMac1 = 8'h04;
    localparam logic [7:0]  AddrFrm  = 8'h05;
    localparam logic [31:0] SwReset  = 32'h0000_2000;
    localparam logic [31:0] Mac0Word =
        {MAC_ADDR[23:16], MAC_ADDR[31:24], MAC_ADDR[39:32], MAC_ADDR[47:40]};
    localparam logic [31:0] Mac1Word = {16'h0, MAC_ADDR[7:0], MAC_ADDR[15:8]};

    typedef enum logic [3:0] {
        StIdle, StRstWr, StPollRd, StPollChk, StMac0Wr, StMac1Wr,
        StFrmWr, StRunWr, StVerRd, StVerChk, StDone, StError
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [BusyW-1:0]  busy_cnt_q, busy_cnt_d;
    logic [PollW-1:0]  poll_cnt_q, poll_cnt_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              cfg_done_q, cfg_err_q;

    logic              acc_req, acc_wr, acc_done;
    logic [7:0]        acc_addr;
    logic [31:0]       acc_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            rdata_q    <= '0;
            busy_cnt_q <= '0;
            poll_cnt_q <= '0;
            err_code_q <= 2'd0;
            cfg_done_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            rdata_q    <= rdata_d;
            busy_cnt_q <= busy_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            err_code_q <= err_code_d;
            cfg_done_q <= (state_d == StDone);
            cfg_err_q  <= (state_d == StError);
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        rdata_d    = rdata_q;
        busy_cnt_d = busy_cnt_q;
        poll_cnt_d = poll_cnt_q;
        err_code_d = err_code_q;
        acc_req    = 1'b1;
        acc_wr     = 1'b1;
        acc_addr   = AddrCmd;
        acc_data   = '0;
        acc_done   = 1'b0;

        case (state_q)
            StRstWr:  acc_data = SwReset;
            StPollRd: acc_wr = 1'b0;
            StMac0Wr: begin acc_addr = AddrMac0; acc_data = Mac0Word; end
            StMac1Wr: begin acc_addr = AddrMac1; acc_data = Mac1Word; end
            StFrmWr:  begin acc_addr = AddrFrm;  acc_data = FRM_LEN;  end
            StRunWr:  acc_data = CMD_RUN;
            StVerRd:  acc_wr = 1'b0;
            default:  acc_req = 1'b0;
        endcase

        // Entry cycle of an access state has no strobe, which provides the idle gap.
        if (acc_req) begin
            if (!(wr_q || rd_q)) begin
                addr_d     = acc_addr;
                wdata_d    = acc_wr ? acc_data : '0;
                wr_d       = acc_wr;
                rd_d       = !acc_wr;
                busy_cnt_d = '0;
            end else if (!reg_busy) begin
                wr_d     = 1'b0;
                rd_d     = 1'b0;
                acc_done = 1'b1;
                if (rd_q) rdata_d = reg_data_out;
            end else if (busy_cnt_q == BusyLast) begin
                wr_d       = 1'b0;
                rd_d       = 1'b0;
                err_code_d = 2'd1;
                state_d    = StError;
            end else begin
                busy_cnt_d = busy_cnt_q + BusyW'(1);
            end
        end

        case (state_q)
            StIdle: if (start) state_d = StRstWr;
            StRstWr: begin
                if (acc_done) begin
                    state_d    = StPollRd;
                    poll_cnt_d = '0;
                end
            end
            StPollRd: if (acc_done) state_d = StPollChk;
            StPollChk: begin
                if (!rdata_q[13]) begin
                    state_d = StMac0Wr;
                end else if (poll_cnt_q == PollLast) begin
                    err_code_d = 2'd2;
                    state_d    = StError;
                end else begin
                    poll_cnt_d = poll_cnt_q + PollW'(1);
                    state_d    = StPollRd;
                end
            end
            StMac0Wr: if (acc_done) state_d = StMac1Wr;
            StMac1Wr: if (acc_done) state_d = StFrmWr;
            StFrmWr:  if (acc_done) state_d = StRunWr;
            StRunWr:  if (acc_done) state_d = StVerRd;
            StVerRd:  if (acc_done) state_d = StVerChk;
            StVerChk: begin
                if ((rdata_q & CMD_RUN) == CMD_RUN) begin
                    err_code_d = 2'd0;
                    state_d    = StDone;
                end else begin
                    err_code_d = 2'd3;
                    state_d    = StError;
                end
            end
            StDone, StError: begin
                if (start) begin
                    err_code_d = 2'd0;
                    state_d    = StRstWr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        if (state_q == StDone) begin
            reg_addr    = host_addr;
            reg_rd      = host_rd;
            reg_wr      = host_wr;
            reg_data_in = host_wdata;
            host_rdata  = reg_data_out;
            host_busy   = reg_busy;
        end else begin
            reg_addr    = addr_q;
            reg_rd      = rd_q;
            reg_wr      = wr_q;
            reg_data_in = wdata_q;
            host_rdata  = '0;
            host_busy   = 1'b1;
        end
    end

    assign cfg_done = cfg_done_q;
    assign cfg_err  = cfg_err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_eth_mac_cfg_seq.sv
// Bench for eth_mac_cfg_seq: behavioural MAC register model, expected-access queue
// built from the bring-up rules, per-cycle protocol checks and directed scenarios.
module tb_eth_mac_cfg_seq;

    localparam logic [47:0] MAC_ADDR = 48'h0002_C5E7_0001;
    localparam logic [31:0] FRM_LEN  = 32'd1518;
    localparam logic [31:0] CMD_RUN  = 32'h0000_0003;
    localparam int          POLL_MAX = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        cfg_done, cfg_err;
    logic [1:0]  err_code;
    logic [7:0]  reg_addr;
    logic        reg_rd, reg_wr;
    logic [31:0] reg_data_in;
    logic [31:0] reg_data_out;
    logic        reg_busy;
    logic [7:0]  host_addr = 8'h0;
    logic        host_rd = 1'b0;
    logic        host_wr = 1'b0;
    logic [31:0] host_wdata = 32'h0;
    logic [31:0] host_rdata;
    logic        host_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    eth_mac_cfg_seq dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_done     (cfg_done),
        .cfg_err      (cfg_err),
        .err_code     (err_code),
        .reg_addr     (reg_addr),
        .reg_rd       (reg_rd),
        .reg_wr       (reg_wr),
        .reg_data_in  (reg_data_in),
        .reg_data_out (reg_data_out),
        .reg_busy     (reg_busy),
        .host_addr    (host_addr),
        .host_rd      (host_rd),
        .host_wr      (host_wr),
        .host_wdata   (host_wdata),
        .host_rdata   (host_rdata),
        .host_busy    (host_busy)
    );

    // MAC model: register file, SW_RESET stays set for sticky_reads reads of 0x02.
    logic [31:0] mac_mem [256];
    int          pending;
    int          mac_busy_cnt;
    int          sticky_reads = 3;
    int          busy_mode = 0;   // 0 never busy, 1 busy 5 cycles per access, 2 stuck
    bit          ver_bad = 1'b0;
    logic        strb_m;

    assign strb_m = reg_wr | reg_rd;

    always_comb begin
        reg_busy = strb_m && ((busy_mode == 2) || (busy_mode == 1 && mac_busy_cnt < 5));
    end

    always_comb begin
        reg_data_out = mac_mem[reg_addr];
        if (reg_addr == 8'h02) begin
            reg_data_out = (mac_mem[2] & ~32'h2000) | ((pending > 0) ? 32'h2000 : 32'h0);
            if (ver_bad && pending == 0 && mac_mem[2] == CMD_RUN) reg_data_out = 32'h1;
        end
    end

    always_ff @(posedge clk) begin
        if (!strb_m) begin
            mac_busy_cnt <= 0;
        end else if (reg_busy) begin
            mac_busy_cnt <= mac_busy_cnt + 1;
        end else begin
            mac_busy_cnt <= 0;
            if (reg_wr) begin
                mac_mem[reg_addr] <= reg_data_in;
                if (reg_addr == 8'h02 && reg_data_in[13]) pending <= sticky_reads;
            end else if (reg_addr == 8'h02 && pending > 0) begin
                pending <= pending - 1;
            end
        end
    end

    // Access record: {is_write, addr, data}
    logic [40:0] exp_q [$];
    logic [40:0] log_q [$];
    int          total_busy = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic void build_seq(input int sticky, input bit bad);
        exp_q.push_back({1'b1, 8'h02, 32'h0000_2000});
        for (int i = 0; i < sticky && i < POLL_MAX; i++) exp_q.push_back({1'b0, 8'h02, 32'h2000});
        if (sticky >= POLL_MAX) return;
        exp_q.push_back({1'b0, 8'h02, 32'h0});
        exp_q.push_back({1'b1, 8'h03,
                         MAC_ADDR[23:16], MAC_ADDR[31:24], MAC_ADDR[39:32], MAC_ADDR[47:40]});
        exp_q.push_back({1'b1, 8'h04, 16'h0, MAC_ADDR[7:0], MAC_ADDR[15:8]});
        exp_q.push_back({1'b1, 8'h05, FRM_LEN});
        exp_q.push_back({1'b1, 8'h02, CMD_RUN});
        exp_q.push_back({1'b0, 8'h02, bad ? 32'h1 : CMD_RUN});
    endfunction

    // Per-cycle monitor: access order, stability under busy, idle gap, host isolation.
    initial begin : monitor
        logic        p_strb, p_busy, p_wr, p_rd, p_rst, p_cmpl, strb;
        logic [7:0]  p_addr;
        logic [31:0] p_data;
        logic [40:0] rec, e;
        int          run_busy;
        p_strb = 0; p_busy = 0; p_wr = 0; p_rd = 0; p_rst = 1; p_cmpl = 0;
        p_addr = 0; p_data = 0; run_busy = 0;
        forever begin
            @(negedge clk);
            strb = reg_wr | reg_rd;
            if (!reset) begin
                if (!cfg_done) begin
                    chk("host_busy_outside_done", host_busy, 1);
                    chk("host_rdata_outside_done", host_rdata, 0);
                end
                if (cfg_err) chk("no_strobe_in_error", strb, 0);
                if (p_strb && p_busy && !p_rst && !cfg_err) begin
                    chk("hold_wr", reg_wr, p_wr);
                    chk("hold_rd", reg_rd, p_rd);
                    chk("hold_addr", reg_addr, p_addr);
                    chk("hold_data", reg_data_in, p_data);
                end
                if (p_cmpl && !cfg_done) chk("strobe_drop_gap", strb, 0);
                if (strb && !reg_busy) begin
                    rec = {reg_wr, reg_addr, reg_wr ? reg_data_in : reg_data_out};
                    log_q.push_back(rec);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_access", rec, 0);
                        if (rec == 0) chk("unexpected_access_zero", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("access_order", rec, e);
                    end
                    if (busy_mode == 1) chk("busy_cycles_per_access", run_busy, 5);
                end
            end
            if (strb && reg_busy) begin
                run_busy++;
                total_busy++;
            end else begin
                run_busy = 0;
            end
            p_strb = strb; p_busy = reg_busy; p_wr = reg_wr; p_rd = reg_rd;
            p_addr = reg_addr; p_data = reg_data_in; p_rst = reset;
            p_cmpl = strb && !reg_busy && !reset;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_end(input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(cfg_done || cfg_err) && n < budget);
        if (!(cfg_done || cfg_err)) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_cfg_done"}, cfg_done, 0);
        chk({name, "_cfg_err"}, cfg_err, 0);
        chk({name, "_err_code"}, err_code, 0);
        chk({name, "_reg_addr"}, reg_addr, 0);
        chk({name, "_reg_rd"}, reg_rd, 0);
        chk({name, "_reg_wr"}, reg_wr, 0);
        chk({name, "_reg_data_in"}, reg_data_in, 0);
        chk({name, "_host_rdata"}, host_rdata, 0);
        chk({name, "_host_busy"}, host_busy, 1);
    endtask

    initial begin : main
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("idle_no_strobe", reg_wr | reg_rd, 0);
        end

        // 1: clean bring-up
        sticky_reads = 3; busy_mode = 0; ver_bad = 0;
        log_q.delete();
        build_seq(3, 0);
        pulse_start();
        wait_end(2000, "t1");
        chk("t1_done", cfg_done, 1);
        chk("t1_err", cfg_err, 0);
        chk("t1_code", err_code, 0);
        chk("t1_drained", exp_q.size(), 0);
        chk("t1_count", log_q.size(), 10);
        if (log_q.size() == 10) begin
            chk("t1_lit_rst", log_q[0], {1'b1, 8'h02, 32'h0000_2000});
            chk("t1_lit_poll3", log_q[3], {1'b0, 8'h02, 32'h0000_2000});
            chk("t1_lit_poll4", log_q[4], {1'b0, 8'h02, 32'h0000_0000});
            chk("t1_lit_mac0", log_q[5], {1'b1, 8'h03, 32'hE7C5_0200});
            chk("t1_lit_mac1", log_q[6], {1'b1, 8'h04, 32'h0000_0100});
            chk("t1_lit_frm", log_q[7], {1'b1, 8'h05, 32'h0000_05EE});
            chk("t1_lit_run", log_q[8], {1'b1, 8'h02, 32'h0000_0003});
            chk("t1_lit_ver", log_q[9], {1'b0, 8'h02, 32'h0000_0003});
        end

        // 2: every access busy for 5 cycles
        busy_mode = 1;
        build_seq(3, 0);
        pulse_start();
        wait_end(3000, "t2");
        chk("t2_done", cfg_done, 1);
        chk("t2_code", err_code, 0);
        chk("t2_drained", exp_q.size(), 0);

        // 3: busy stuck on the SW_RESET write
        busy_mode = 2;
        pulse_start();
        total_busy = 0;
        wait_end(3000, "t3");
        chk("t3_err", cfg_err, 1);
        chk("t3_done", cfg_done, 0);
        chk("t3_code", err_code, 1);
        chk("t3_reg_wr", reg_wr, 0);
        chk("t3_busy_cycles", total_busy, 1023);
        chk("t3_drained", exp_q.size(), 0);
        busy_mode = 0;

        // 4: SW_RESET never clears, then recovery
        sticky_reads = 1000;
        log_q.delete();
        build_seq(1000, 0);
        pulse_start();
        wait_end(3000, "t4a");
        chk("t4_err", cfg_err, 1);
        chk("t4_code", err_code, 2);
        chk("t4_accesses", log_q.size(), 65);
        chk("t4_drained", exp_q.size(), 0);
        sticky_reads = 3;
        build_seq(3, 0);
        pulse_start();
        wait_end(2000, "t4b");
        chk("t4_recover_done", cfg_done, 1);
        chk("t4_recover_code", err_code, 0);
        chk("t4b_drained", exp_q.size(), 0);

        // 5: verify mismatch, host isolation before DONE, passthrough in DONE
        ver_bad = 1;
        build_seq(3, 1);
        pulse_start();
        wait_end(2000, "t5a");
        chk("t5_err", cfg_err, 1);
        chk("t5_code", err_code, 3);
        chk("t5a_drained", exp_q.size(), 0);
        @(posedge clk); #1 host_addr = 8'h17; host_rd = 1'b1;
        @(negedge clk);
        chk("t5_iso_reg_rd", reg_rd, 0);
        chk("t5_iso_reg_wr", reg_wr, 0);
        chk("t5_iso_host_busy", host_busy, 1);
        @(posedge clk); #1 host_rd = 1'b0;
        ver_bad = 0;
        build_seq(3, 0);
        pulse_start();
        wait_end(2000, "t5b");
        chk("t5_done", cfg_done, 1);
        chk("t5b_drained", exp_q.size(), 0);
        exp_q.push_back({1'b1, 8'h17, 32'h0000_00A5});
        @(posedge clk); #1 host_addr = 8'h17; host_wdata = 32'hA5; host_wr = 1'b1;
        @(negedge clk);
        chk("t5_pt_wr", reg_wr, 1);
        chk("t5_pt_addr", reg_addr, 8'h17);
        chk("t5_pt_wdata", reg_data_in, 32'hA5);
        exp_q.push_back({1'b0, 8'h17, 32'h0000_00A5});
        @(posedge clk); #1 host_wr = 1'b0; host_rd = 1'b1;
        @(negedge clk);
        chk("t5_pt_rd", reg_rd, 1);
        chk("t5_pt_rdata", host_rdata, 32'hA5);
        chk("t5_pt_busy", host_busy, 0);
        @(posedge clk); #1 host_rd = 1'b0; host_wdata = 32'h0; host_addr = 8'h0;
        @(negedge clk);
        chk("t5c_drained", exp_q.size(), 0);

        // 6: reset in the middle of a busy MAC0 write
        busy_mode = 1;
        build_seq(3, 0);
        pulse_start();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(reg_wr && reg_addr == 8'h03 && reg_busy) && n < 500);
        chk("t6_reached_mac0", reg_wr && reg_addr == 8'h03 && reg_busy, 1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("t6");
        exp_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t6_idle_no_strobe", reg_wr | reg_rd, 0);
            chk("t6_idle_no_done", cfg_done, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
